icache_direct: RTL

// - Direct-mapped, read-only instruction cache between the single-cycle datapath fetch port and the memory controller.
// - Returns hits combinationally in the request cycle.
// - Fetches misses one word at a time, stalling the datapath through ihit = 0.
// - Datapath PC is held while ihit = 0, so the stall freezes fetch until the fill completes.

---
 rtl/icache_direct.sv | 133 +++++++++++++
 1 files changed

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache.
// Hits return combinationally; misses fill one word from memory, with ihit
// held low to stall the datapath. Optional hit/miss counters are enabled by
// the ICACHE_STATS_EN macro.
module icache_direct #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,      // active-high asynchronous reset
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t                      state_q, state_d;
  // Only the word address is kept; the byte offset is always zero.
  logic [29:0]                 miss_addr_q, miss_addr_d;
  logic [SETS-1:0]             valid_q, valid_d;
  logic [SETS-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [SETS-1:0][31:0]       data_q, data_d;

  logic [IDX_W-1:0] req_idx, miss_idx;
  logic [TAG_W-1:0] req_tag, miss_tag;
  logic             lookup_hit;
  logic             unused_ok;

  assign req_idx   = imemaddr[IDX_W+1:2];
  assign req_tag   = imemaddr[31:IDX_W+2];
  assign miss_idx  = miss_addr_q[IDX_W-1:0];
  assign miss_tag  = miss_addr_q[29:IDX_W];
  assign unused_ok = ^imemaddr[1:0];

  // Tag compare against the frame selected by the request index.
  always_comb begin
    lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  end

  // Next-state, fill write and output decode; everything idles under reset.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    if (!nRST) begin
      case (state_q)
        IDLE: begin
          if (imemREN) begin
            if (lookup_hit) begin
              ihit     = 1'b1;
              imemload = data_q[req_idx];
            end else begin
              miss_addr_d = imemaddr[31:2];
              state_d     = FETCH;
            end
          end
        end
        FETCH: begin
          // The fill always runs to completion on the latched address.
          iREN  = 1'b1;
          iaddr = {miss_addr_q, 2'b00};
          if (!iwait) begin
            valid_d[miss_idx] = 1'b1;
            tag_d[miss_idx]   = miss_tag;
            data_d[miss_idx]  = iload;
            state_d           = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Cache state register; reset drops any in-flight fill and empties the cache.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      valid_q     <= '0;
      tag_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Free-running wrap-around counters of hit cycles and miss entries.
  always_comb begin
    hit_count_d  = hit_count_q + {31'd0, ihit};
    miss_count_d = miss_count_q + {31'd0, (state_q == IDLE) && (state_d == FETCH)};
  end

  // Counter registers.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule
